// File: rtl/writeback_unit.sv
// Final pipeline stage: commits ALU results or load data to the register file write port,
// stalls upstream while a load is outstanding and offers same-cycle read forwarding.
module writeback_unit #(
    parameter int DATA_W      = 32,
    parameter int REG_AW      = 4,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_in,
    input  logic [DATA_W-1:0] instruction_in,
    input  logic              condition_in,
    input  logic              LS_in,
    input  logic [REG_AW-1:0] dest_in,
    input  logic [DATA_W-1:0] result_in,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_data_in,
    output logic              stall_out,
    output logic              mem_req,
    output logic              wr1,
    output logic [REG_AW-1:0] wrReg1,
    output logic [DATA_W-1:0] wrData1,
    output logic              pc_load,
    input  logic [REG_AW-1:0] rd_reg1,
    input  logic [REG_AW-1:0] rd_reg2,
    output logic              fwd1_hit,
    output logic              fwd2_hit,
    output logic [DATA_W-1:0] fwd_data,
    output logic [DATA_W-1:0] instruction_out,
    output logic [15:0]       retire_count,
    output logic              fault
);

    typedef enum logic {
        IDLE,
        WAIT_MEM
    } state_t;

    localparam logic [7:0]        TMO_LIMIT = 8'(MEM_TIMEOUT);
    localparam logic [REG_AW-1:0] PC_REG    = REG_AW'(15);
    localparam logic [REG_AW-1:0] ZERO_REG  = '0;

    state_t              r_state;
    logic [7:0]          r_tmo_cnt;
    logic [REG_AW-1:0]   r_ld_dest;
    logic [DATA_W-1:0]   r_ld_instr;
    logic                r_wr1;
    logic [REG_AW-1:0]   r_wr_reg;
    logic [DATA_W-1:0]   r_wr_data;
    logic [DATA_W-1:0]   r_instr_out;
    logic [15:0]         r_retire_cnt;
    logic                r_fault;

    state_t              w_state_next;
    logic [7:0]          w_tmo_cnt_next;
    logic                w_load_start;
    logic                w_commit;
    logic [REG_AW-1:0]   w_commit_dest;
    logic [DATA_W-1:0]   w_commit_data;
    logic [DATA_W-1:0]   w_commit_instr;
    logic                w_timeout;
    logic                w_do_write;

    // NOTE: every signal gets a default before the case so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        w_state_next   = r_state;
        w_tmo_cnt_next = r_tmo_cnt;
        w_load_start   = 1'b0;
        w_commit       = 1'b0;
        w_commit_dest  = dest_in;
        w_commit_data  = result_in;
        w_commit_instr = instruction_in;
        w_timeout      = 1'b0;
        case (r_state)
            IDLE: begin
                if (valid_in && condition_in) begin
                    if (LS_in) begin
                        w_load_start   = 1'b1;
                        w_tmo_cnt_next = '0;
                        w_state_next   = WAIT_MEM;
                    end else begin
                        w_commit = 1'b1;
                    end
                end
            end
            WAIT_MEM: begin
                w_tmo_cnt_next = r_tmo_cnt + 8'd1;
                // Data arriving on the final allowed cycle still commits.
                if (mem_ready) begin
                    w_commit       = 1'b1;
                    w_commit_dest  = r_ld_dest;
                    w_commit_data  = mem_data_in;
                    w_commit_instr = r_ld_instr;
                    w_state_next   = IDLE;
                end else if (w_tmo_cnt_next == TMO_LIMIT) begin
                    w_timeout    = 1'b1;
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // r0 is hardwired zero: the instruction retires but never reaches the write port.
    assign w_do_write = w_commit && (w_commit_dest != ZERO_REG);

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_tmo_cnt    <= '0;
            r_ld_dest    <= '0;
            r_ld_instr   <= '0;
            r_wr1        <= 1'b0;
            r_wr_reg     <= '0;
            r_wr_data    <= '0;
            r_instr_out  <= '0;
            r_retire_cnt <= '0;
            r_fault      <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_tmo_cnt <= w_tmo_cnt_next;
            r_wr1     <= w_do_write;
            if (w_load_start) begin
                r_ld_dest  <= dest_in;
                r_ld_instr <= instruction_in;
            end
            if (w_do_write) begin
                r_wr_reg  <= w_commit_dest;
                r_wr_data <= w_commit_data;
            end
            if (w_commit) begin
                r_instr_out  <= w_commit_instr;
                r_retire_cnt <= r_retire_cnt + 16'd1;
            end
            if (w_timeout) begin
                r_fault <= 1'b1;
            end
        end
    end

    assign stall_out       = (r_state == WAIT_MEM);
    assign mem_req         = (r_state == WAIT_MEM);
    assign wr1             = r_wr1;
    assign wrReg1          = r_wr_reg;
    assign wrData1         = r_wr_data;
    assign pc_load         = r_wr1 && (r_wr_reg == PC_REG);
    assign fwd1_hit        = r_wr1 && (r_wr_reg == rd_reg1) && (r_wr_reg != ZERO_REG);
    assign fwd2_hit        = r_wr1 && (r_wr_reg == rd_reg2) && (r_wr_reg != ZERO_REG);
    assign fwd_data        = r_wr_data;
    assign instruction_out = r_instr_out;
    assign retire_count    = r_retire_cnt;
    assign fault           = r_fault;

endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit: a cycle-level reference model checked every cycle,
// plus hand-computed literal expectations at the key points of each scenario.
module tb_writeback_unit;

    localparam int DATA_W      = 32;
    localparam int REG_AW      = 4;
    localparam int MEM_TIMEOUT = 15;

    logic              clk;
    logic              reset;
    logic              valid_in;
    logic [DATA_W-1:0] instruction_in;
    logic              condition_in;
    logic              LS_in;
    logic [REG_AW-1:0] dest_in;
    logic [DATA_W-1:0] result_in;
    logic              mem_ready;
    logic [DATA_W-1:0] mem_data_in;
    logic              stall_out;
    logic              mem_req;
    logic              wr1;
    logic [REG_AW-1:0] wrReg1;
    logic [DATA_W-1:0] wrData1;
    logic              pc_load;
    logic [REG_AW-1:0] rd_reg1;
    logic [REG_AW-1:0] rd_reg2;
    logic              fwd1_hit;
    logic              fwd2_hit;
    logic [DATA_W-1:0] fwd_data;
    logic [DATA_W-1:0] instruction_out;
    logic [15:0]       retire_count;
    logic              fault;

    writeback_unit #(
        .DATA_W(DATA_W), .REG_AW(REG_AW), .MEM_TIMEOUT(MEM_TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .instruction_in(instruction_in),
        .condition_in(condition_in), .LS_in(LS_in), .dest_in(dest_in), .result_in(result_in),
        .mem_ready(mem_ready), .mem_data_in(mem_data_in), .stall_out(stall_out),
        .mem_req(mem_req), .wr1(wr1), .wrReg1(wrReg1), .wrData1(wrData1), .pc_load(pc_load),
        .rd_reg1(rd_reg1), .rd_reg2(rd_reg2), .fwd1_hit(fwd1_hit), .fwd2_hit(fwd2_hit),
        .fwd_data(fwd_data), .instruction_out(instruction_out), .retire_count(retire_count),
        .fault(fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a load is "outstanding" for a number of elapsed wait cycles;
    // every commit bumps the count and, unless aimed at r0, produces a one-cycle write.
    logic              m_busy;
    int                m_waited;
    logic [REG_AW-1:0] m_ld_dest;
    logic [DATA_W-1:0] m_ld_instr;
    logic              m_wr;
    logic [REG_AW-1:0] m_reg;
    logic [DATA_W-1:0] m_data;
    logic [DATA_W-1:0] m_instr;
    int unsigned       m_count;
    logic              m_fault;

    task automatic m_reset();
        m_busy = 0; m_waited = 0; m_ld_dest = '0; m_ld_instr = '0;
        m_wr = 0; m_reg = '0; m_data = '0; m_instr = '0; m_count = 0; m_fault = 0;
    endtask

    task automatic m_commit(input logic [REG_AW-1:0] d, input logic [DATA_W-1:0] v,
                            input logic [DATA_W-1:0] ins);
        m_count = (m_count + 1) % 65536;
        m_instr = ins;
        if (d != 0) begin
            m_wr = 1; m_reg = d; m_data = v;
        end
    endtask

    task automatic m_step();
        m_wr = 0;
        if (!m_busy) begin
            if (valid_in && condition_in) begin
                if (LS_in) begin
                    m_busy = 1; m_waited = 0; m_ld_dest = dest_in; m_ld_instr = instruction_in;
                end else begin
                    m_commit(dest_in, result_in, instruction_in);
                end
            end
        end else begin
            m_waited++;
            if (mem_ready) begin
                m_commit(m_ld_dest, mem_data_in, m_ld_instr);
                m_busy = 0;
            end else if (m_waited >= MEM_TIMEOUT) begin
                m_fault = 1;
                m_busy  = 0;
            end
        end
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge clk);
            if (!reset) m_reset();
            else m_step();
            #1;
            check("stall_out", stall_out, m_busy);
            check("mem_req", mem_req, m_busy);
            check("wr1", wr1, m_wr);
            check("wrReg1", wrReg1, m_reg);
            check("wrData1", wrData1, m_data);
            check("pc_load", pc_load, m_wr && (m_reg == 15));
            check("fwd1_hit", fwd1_hit, m_wr && (m_reg == rd_reg1) && (m_reg != 0));
            check("fwd2_hit", fwd2_hit, m_wr && (m_reg == rd_reg2) && (m_reg != 0));
            check("fwd_data", fwd_data, m_data);
            check("instruction_out", instruction_out, m_instr);
            check("retire_count", retire_count, m_count[15:0]);
            check("fault", fault, m_fault);
        end
    end

    task automatic send(input logic cond, input logic ls, input logic [REG_AW-1:0] dest,
                        input logic [DATA_W-1:0] res, input logic [DATA_W-1:0] instr);
        valid_in = 1; condition_in = cond; LS_in = ls; dest_in = dest;
        result_in = res; instruction_in = instr;
        @(negedge clk);
        valid_in = 0;
    endtask

    task automatic apply_reset();
        reset = 0; valid_in = 0; mem_ready = 0;
        #1;
        check("rst_stall", stall_out, 0);
        check("rst_mem_req", mem_req, 0);
        check("rst_wr1", wr1, 0);
        check("rst_wrReg1", wrReg1, 0);
        check("rst_wrData1", wrData1, 0);
        check("rst_instr", instruction_out, 0);
        check("rst_count", retire_count, 0);
        check("rst_fault", fault, 0);
        @(negedge clk);
        reset = 1;
    endtask

    initial begin
        reset = 0; valid_in = 0; instruction_in = '0; condition_in = 0; LS_in = 0;
        dest_in = '0; result_in = '0; mem_ready = 0; mem_data_in = '0;
        rd_reg1 = '0; rd_reg2 = '0;
        @(negedge clk);
        apply_reset();
        @(negedge clk);

        // Back-to-back ALU commits
        send(1, 0, 4'd3, 32'h11, 32'hA000_0003);
        check("b2b0_wr1", wr1, 1);
        check("b2b0_reg", wrReg1, 3);
        check("b2b0_data", wrData1, 32'h11);
        send(1, 0, 4'd4, 32'h22, 32'hA000_0004);
        check("b2b1_wr1", wr1, 1);
        check("b2b1_reg", wrReg1, 4);
        check("b2b1_data", wrData1, 32'h22);
        check("b2b_count", retire_count, 2);
        check("b2b_stall", stall_out, 0);

        // Annulled, then a normal commit
        send(0, 0, 4'd5, 32'hFF, 32'hB000_0005);
        check("annul_wr1", wr1, 0);
        check("annul_count", retire_count, 2);
        send(1, 0, 4'd6, 32'h66, 32'hA000_0006);
        check("post_annul_wr1", wr1, 1);
        check("post_annul_count", retire_count, 3);

        // Load with mem_ready in the third wait cycle; ALU op held during the stall
        send(1, 1, 4'd7, 32'h0, 32'hC000_0007);
        valid_in = 1; condition_in = 1; LS_in = 0; dest_in = 4'd8;
        result_in = 32'h88; instruction_in = 32'hA000_0008;
        check("ld_stall1", stall_out, 1);
        @(negedge clk);
        check("ld_stall2", stall_out, 1);
        @(negedge clk);
        check("ld_stall3", stall_out, 1);
        check("ld_mem_req", mem_req, 1);
        mem_ready = 1; mem_data_in = 32'hDEADBEEF;
        @(negedge clk);
        mem_ready = 0;
        check("ld_stall_drop", stall_out, 0);
        check("ld_wr1", wr1, 1);
        check("ld_reg", wrReg1, 7);
        check("ld_data", wrData1, 32'hDEADBEEF);
        check("ld_instr", instruction_out, 32'hC000_0007);
        check("ld_count", retire_count, 4);
        @(negedge clk);
        valid_in = 0;
        check("held_reg", wrReg1, 8);
        check("held_data", wrData1, 32'h88);
        check("held_count", retire_count, 5);
        check("model_count5", m_count, 5);

        // Reset while a load is outstanding
        send(1, 1, 4'd6, 32'h0, 32'hC000_0006);
        @(negedge clk);
        check("midld_stall", stall_out, 1);
        apply_reset();
        mem_ready = 1; mem_data_in = 32'h1234;
        @(negedge clk);
        mem_ready = 0;
        check("midld_no_wr", wr1, 0);
        check("midld_idle", stall_out, 0);

        // Forwarding, r0 and r15
        rd_reg1 = 4'd9; rd_reg2 = 4'd2;
        send(1, 0, 4'd9, 32'h99, 32'hA000_0009);
        check("fwd1", fwd1_hit, 1);
        check("fwd2", fwd2_hit, 0);
        check("fwd_data_lit", fwd_data, 32'h99);
        rd_reg1 = 4'd0; rd_reg2 = 4'd0;
        send(1, 0, 4'd0, 32'h77, 32'hA000_0000);
        check("r0_wr1", wr1, 0);
        check("r0_fwd1", fwd1_hit, 0);
        check("r0_instr", instruction_out, 32'hA000_0000);
        check("r0_count", retire_count, 2);
        send(1, 0, 4'd15, 32'h100, 32'hA000_000F);
        check("pc_wr1", wr1, 1);
        check("pc_load_lit", pc_load, 1);
        @(negedge clk);
        check("pc_load_drop", pc_load, 0);

        // Timeout with no data
        send(1, 1, 4'd10, 32'h0, 32'hC000_000A);
        repeat (MEM_TIMEOUT - 1) @(negedge clk);
        check("tmo_pre_fault", fault, 0);
        check("tmo_pre_stall", stall_out, 1);
        @(negedge clk);
        check("tmo_fault", fault, 1);
        check("tmo_stall", stall_out, 0);
        check("tmo_no_wr", wr1, 0);
        check("tmo_count", retire_count, 3);
        @(negedge clk);
        check("tmo_sticky", fault, 1);

        // Data arrives on the last allowed cycle
        apply_reset();
        send(1, 1, 4'd11, 32'h0, 32'hC000_000B);
        repeat (MEM_TIMEOUT - 1) @(negedge clk);
        mem_ready = 1; mem_data_in = 32'hCAFEF00D;
        @(negedge clk);
        mem_ready = 0;
        check("last_wr1", wr1, 1);
        check("last_reg", wrReg1, 11);
        check("last_data", wrData1, 32'hCAFEF00D);
        check("last_fault", fault, 0);
        check("last_count", retire_count, 1);
        check("model_count1", m_count, 1);

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
